// File: rtl/rv_stream_arbiter.sv
// ============================================================================
// Module   : rv_stream_arbiter
// Brief    : Round-robin merge of NUM_REQ ready/valid streams with packet lock
//            and a single registered forward stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_stream_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clock_port,
    input  logic                          reset_port,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         output_port_data,
    output logic                          output_port_last,
    output logic [ID_WIDTH-1:0]           output_port_id,
    output logic                          output_port_valid,
    input  logic                          output_port_ready
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]            r_state;
    logic [ID_WIDTH-1:0]   r_owner;
    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_valid;

    logic                  w_accept;
    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_cand;
    logic [ID_WIDTH-1:0]   w_search_id;
    logic [ID_WIDTH-1:0]   w_grant_id;
    logic                  w_grant_any;
    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_xfer;
    logic                  w_xfer_last;
    logic [DATA_WIDTH-1:0] w_xfer_data;
    logic [ID_WIDTH-1:0]   w_next_ptr;

    assign w_accept = ~r_valid | output_port_ready;

    // Rotating-priority search starting at the round-robin pointer.
    always_comb begin
        w_found     = 1'b0;
        w_search_id = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = ID_WIDTH'((32'(r_rr_ptr) + 32'(k)) % 32'(NUM_REQ));
            if (!w_found && req_valid[w_cand]) begin
                w_found     = 1'b1;
                w_search_id = w_cand;
            end
        end
    end

    assign w_grant_id  = (r_state == S_LOCKED) ? r_owner : w_search_id;
    assign w_grant_any = (r_state == S_LOCKED) | w_found;

    always_comb begin
        w_ready = '0;
        if (w_grant_any && w_accept) begin
            w_ready[w_grant_id] = 1'b1;
        end
    end

    assign req_ready   = w_ready;
    assign w_xfer      = |(req_valid & w_ready);
    assign w_xfer_last = req_last[w_grant_id];
    assign w_xfer_data = req_data[w_grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign w_next_ptr  = (w_grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                : w_grant_id + 1'b1;

    always_ff @(posedge clock_port or negedge reset_port) begin
        if (!reset_port) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_id    <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_xfer_data;
            r_last  <= w_xfer_last;
            r_id    <= w_grant_id;
        end else if (output_port_ready) begin
            r_valid <= 1'b0;
        end
    end

    // The pointer only advances on packet boundaries so a locked packet
    // does not cost the next requester its turn.
    always_ff @(posedge clock_port or negedge reset_port) begin
        if (!reset_port) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            if (w_xfer_last) begin
                r_state  <= S_IDLE;
                r_rr_ptr <= w_next_ptr;
            end else begin
                r_state <= S_LOCKED;
                r_owner <= w_grant_id;
            end
        end
    end

    assign output_port_data  = r_data;
    assign output_port_last  = r_last;
    assign output_port_id    = r_id;
    assign output_port_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_rv_stream_arbiter.sv
// ============================================================================
// Module   : tb_rv_stream_arbiter
// Brief    : Vector-table bench for rv_stream_arbiter (4x8 and 2x16 builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_stream_arbiter;

    logic        clk;
    logic        reset_port;

    logic [31:0] a_data;
    logic [3:0]  a_last;
    logic [3:0]  a_valid;
    logic [3:0]  a_ready;
    logic [7:0]  a_odata;
    logic        a_olast;
    logic [1:0]  a_oid;
    logic        a_ovalid;
    logic        a_oready;

    logic [31:0] b_data;
    logic [1:0]  b_last;
    logic [1:0]  b_valid;
    logic [1:0]  b_ready;
    logic [15:0] b_odata;
    logic        b_olast;
    logic [0:0]  b_oid;
    logic        b_ovalid;
    logic        b_oready;

    int n_checks = 0;
    int n_fail   = 0;

    rv_stream_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4)) u_dut_a (
        .clock_port        (clk),
        .reset_port        (reset_port),
        .req_data          (a_data),
        .req_last          (a_last),
        .req_valid         (a_valid),
        .req_ready         (a_ready),
        .output_port_data  (a_odata),
        .output_port_last  (a_olast),
        .output_port_id    (a_oid),
        .output_port_valid (a_ovalid),
        .output_port_ready (a_oready)
    );

    rv_stream_arbiter #(.DATA_WIDTH(16), .NUM_REQ(2)) u_dut_b (
        .clock_port        (clk),
        .reset_port        (reset_port),
        .req_data          (b_data),
        .req_last          (b_last),
        .req_valid         (b_valid),
        .req_ready         (b_ready),
        .output_port_data  (b_odata),
        .output_port_last  (b_olast),
        .output_port_id    (b_oid),
        .output_port_valid (b_ovalid),
        .output_port_ready (b_oready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        oready;
        logic [3:0]  exp_ready;
        logic        exp_ovalid;
        logic [7:0]  exp_data;
        logic [1:0]  exp_id;
        logic        exp_last;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l,
                                input logic [31:0] d, input logic o,
                                input logic [3:0] er, input logic ev,
                                input logic [7:0] ed, input logic [1:0] ei,
                                input logic el);
        vec_t t;
        t.valid = v; t.last = l; t.data = d; t.oready = o;
        t.exp_ready = er; t.exp_ovalid = ev; t.exp_data = ed;
        t.exp_id = ei; t.exp_last = el;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // {valid, last, data{r3,r2,r1,r0}, oready} -> {ready, ovalid, data, id, last}
        tbl[0]  = mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'h00, 2'd0, 0);
        tbl[1]  = mk(4'b0100, 4'b0100, 32'h00A5_0000, 1, 4'b0100, 1, 8'hA5, 2'd2, 1);
        tbl[2]  = mk(4'b1111, 4'b1111, 32'h3322_1144, 1, 4'b1000, 1, 8'h33, 2'd3, 1);
        tbl[3]  = mk(4'b1111, 4'b1111, 32'h3322_1144, 1, 4'b0001, 1, 8'h44, 2'd0, 1);
        tbl[4]  = mk(4'b1111, 4'b1111, 32'h3322_1144, 1, 4'b0010, 1, 8'h11, 2'd1, 1);
        tbl[5]  = mk(4'b1111, 4'b1111, 32'h3322_1144, 1, 4'b0100, 1, 8'h22, 2'd2, 1);
        tbl[6]  = mk(4'b1111, 4'b1111, 32'h3322_1144, 1, 4'b1000, 1, 8'h33, 2'd3, 1);
        tbl[7]  = mk(4'b1111, 4'b1111, 32'h3322_1144, 1, 4'b0001, 1, 8'h44, 2'd0, 1);
        tbl[8]  = mk(4'b0111, 4'b0101, 32'h00C2_B1A0, 1, 4'b0010, 1, 8'hB1, 2'd1, 0);
        tbl[9]  = mk(4'b0101, 4'b0101, 32'h00C2_B1A0, 1, 4'b0010, 0, 8'hB1, 2'd1, 0);
        tbl[10] = mk(4'b0111, 4'b0101, 32'h00C2_B2A0, 1, 4'b0010, 1, 8'hB2, 2'd1, 0);
        tbl[11] = mk(4'b0111, 4'b0111, 32'h00C2_B3A0, 1, 4'b0010, 1, 8'hB3, 2'd1, 1);
        tbl[12] = mk(4'b0101, 4'b0101, 32'h00C2_00A0, 1, 4'b0100, 1, 8'hC2, 2'd2, 1);
        for (int i = 13; i < 18; i++)
            tbl[i] = mk(4'b0001, 4'b0001, 32'h0000_005A, 0, 4'b0000, 1, 8'hC2, 2'd2, 1);
        tbl[18] = mk(4'b0001, 4'b0001, 32'h0000_005A, 1, 4'b0001, 1, 8'h5A, 2'd0, 1);
        tbl[19] = mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'h5A, 2'd0, 1);

        reset_port = 1'b0;
        a_valid = '0; a_last = '0; a_data = '0; a_oready = 1'b1;
        b_valid = '0; b_last = '0; b_data = '0; b_oready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ovalid", 32'(a_ovalid), 0);
        check("rst_a_data", 32'(a_odata), 0);
        check("rst_b_ovalid", 32'(b_ovalid), 0);
        @(negedge clk);
        reset_port = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            a_valid  = tbl[i].valid;
            a_last   = tbl[i].last;
            a_data   = tbl[i].data;
            a_oready = tbl[i].oready;
            #1;
            check($sformatf("v%0d_ready", i), 32'(a_ready), 32'(tbl[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ovalid", i), 32'(a_ovalid), 32'(tbl[i].exp_ovalid));
            check($sformatf("v%0d_data", i), 32'(a_odata), 32'(tbl[i].exp_data));
            check($sformatf("v%0d_id", i), 32'(a_oid), 32'(tbl[i].exp_id));
            check($sformatf("v%0d_last", i), 32'(a_olast), 32'(tbl[i].exp_last));
        end

        // Lock onto requester 3, then reset asynchronously between edges.
        a_valid = 4'b1000; a_last = 4'b0000; a_data = 32'hD300_0000; a_oready = 1'b1;
        #1;
        check("lk3_ready", 32'(a_ready), 32'b1000);
        @(posedge clk);
        #1;
        check("lk3_id", 32'(a_oid), 3);
        check("lk3_ovalid", 32'(a_ovalid), 1);
        a_valid = 4'b1111; a_last = 4'b1111; a_data = 32'h4433_22E0;
        #1;
        check("lk3_hold_ready", 32'(a_ready), 32'b1000);
        #1;
        reset_port = 1'b0;
        #1;
        check("arst_ovalid", 32'(a_ovalid), 0);
        check("arst_data", 32'(a_odata), 0);
        check("arst_ready", 32'(a_ready), 32'b0001);
        #2;
        reset_port = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_id", 32'(a_oid), 0);
        check("post_rst_data", 32'(a_odata), 32'hE0);
        check("post_rst_ovalid", 32'(a_ovalid), 1);
        a_valid = '0;

        // Narrow build: alternating single-beat traffic.
        b_valid = 2'b11; b_last = 2'b11; b_data = 32'hBEEF_1234; b_oready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("b%0d_ready", i), 32'(b_ready), (i % 2 == 0) ? 32'b01 : 32'b10);
            @(posedge clk);
            #1;
            check($sformatf("b%0d_id", i), 32'(b_oid), 32'(i % 2));
            check($sformatf("b%0d_data", i), 32'(b_odata),
                  (i % 2 == 0) ? 32'h1234 : 32'hBEEF);
            check($sformatf("b%0d_ovalid", i), 32'(b_ovalid), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
